// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU. Performs
//            one radix-2 shift-add or restoring-divide step per cycle and
//            returns Hi/Lo on a valid/ready response channel.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready, op[1:0], operandA, operandB  - request
//            resp_valid/resp_ready, Hi, Lo, div_by_zero         - response
//            busy - high while an operation is in flight or awaiting handoff
// Options  : MULDIV_ZERO_BYPASS_EN - when defined, operations with a trivially
//            zero result skip the iterative path and respond one cycle after
//            acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;     // negate product / quotient
    logic               neg_hi_q, neg_hi_d;     // negate remainder
    logic               byp_q, byp_d;           // skip the iterative path
    logic               byp_dbz_q, byp_dbz_d;   // bypass is a divide-by-zero
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;           // {partial hi / remainder, multiplier / quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               resp_valid_q, resp_valid_d;
    logic               dbz_q, dbz_d;

    // Request decode (only meaningful in IDLE)
    logic               w_sign_a, w_sign_b, w_dbz, w_zero;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;

    assign w_sign_a = ~op[0] & operandA[WIDTH-1];
    assign w_sign_b = ~op[0] & operandB[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -operandA : operandA;
    assign w_mag_b  = w_sign_b ? -operandB : operandB;
    assign w_dbz    = op[1] & (operandB == '0);

`ifdef MULDIV_ZERO_BYPASS_EN
    assign w_zero = op[1] ? (operandA == '0)
                          : ((operandA == '0) | (operandB == '0));
`else
    assign w_zero = 1'b0;
`endif

    // Multiply step: conditionally add multiplicand to upper half, shift right.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + {1'b0, (acc_q[0] ? mag_b_q : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. The kept remainder is always below
    // the divisor, so it fits back into WIDTH bits.
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, mag_b_q});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - mag_b_q;
    assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                          acc_q[WIDTH-2:0], w_div_ge};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_div_d     = is_div_q;
        neg_lo_d     = neg_lo_q;
        neg_hi_d     = neg_hi_q;
        byp_d        = byp_q;
        byp_dbz_d    = byp_dbz_q;
        mag_b_d      = mag_b_q;
        acc_d        = acc_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        resp_valid_d = resp_valid_q;
        dbz_d        = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_div_d  = op[1];
                    neg_lo_d  = w_sign_a ^ w_sign_b;
                    neg_hi_d  = op[1] & w_sign_a;   // remainder follows dividend
                    mag_b_d   = w_mag_b;
                    // Divide-by-zero returns the raw dividend in Hi, so keep it unmodified.
                    acc_d     = {{WIDTH{1'b0}}, (w_dbz ? operandA : w_mag_a)};
                    byp_d     = w_dbz | w_zero;
                    byp_dbz_d = w_dbz;
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (byp_q) begin
                    hi_d         = byp_dbz_q ? acc_q[WIDTH-1:0] : {WIDTH{1'b0}};
                    lo_d         = byp_dbz_q ? {WIDTH{1'b1}}    : {WIDTH{1'b0}};
                    dbz_d        = byp_dbz_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    acc_d = is_div_q ? w_div_next : w_mul_next;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
                resp_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_div_q     <= 1'b0;
            neg_lo_q     <= 1'b0;
            neg_hi_q     <= 1'b0;
            byp_q        <= 1'b0;
            byp_dbz_q    <= 1'b0;
            mag_b_q      <= '0;
            acc_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_div_q     <= is_div_d;
            neg_lo_q     <= neg_lo_d;
            neg_hi_q     <= neg_hi_d;
            byp_q        <= byp_d;
            byp_dbz_q    <= byp_dbz_d;
            mag_b_q      <= mag_b_d;
            acc_q        <= acc_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            dbz_q        <= dbz_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit. Directed cases followed by
//            randomized operations, compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         resp_ready = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         req_ready, resp_valid, div_by_zero, busy;
    logic [W-1:0] Hi, Lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .op          (op),
        .operandA    (operandA),
        .operandB    (operandB),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .Hi          (Hi),
        .Lo          (Lo),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [W-1:0] e_hi, e_lo;
    logic         e_dbz;
    int           e_lat;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands' numeric values.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        p     = '0;
        e_dbz = 1'b0;
        e_lat = W + 1;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == '0) begin
                    p = {a, 32'hFFFF_FFFF}; e_dbz = 1'b1; e_lat = 1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == '0) begin
                    p = {a, 32'hFFFF_FFFF}; e_dbz = 1'b1; e_lat = 1;
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        if (ZB && ((!o[1] && (a == '0 || b == '0)) || (o[1] && a == '0 && b != '0)))
            e_lat = 1;
        e_hi = p[63:32];
        e_lo = p[31:0];
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waited);
        int n;
        model(o, a, b);
        op        = o;
        operandA  = a;
        operandB  = b;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", (n < 200), 1);
        waited = n;
        @(posedge clk); #1;
        req_valid = 1'b0;
        operandA  = $urandom;
        operandB  = $urandom;
        op        = 2'($urandom_range(0, 3));
        check("acc_busy",      busy,        1);
        check("acc_req_ready", req_ready,   0);
        check("acc_resp_vld",  resp_valid,  0);
        check("acc_dbz_clr",   div_by_zero, 0);
        check("acc_hi_keep",   Hi,          last_hi);
        check("acc_lo_keep",   Lo,          last_lo);
    endtask

    task automatic await_resp();
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("latency",   n,           e_lat);
        check("resp_hi",   Hi,          e_hi);
        check("resp_lo",   Lo,          e_lo);
        check("resp_dbz",  div_by_zero, e_dbz);
        check("resp_busy", busy,        1);
        check("resp_rdy",  req_ready,   0);
        last_hi = e_hi;
        last_lo = e_lo;
    endtask

    task automatic release_resp(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid,  1);
            check("hold_hi",    Hi,          e_hi);
            check("hold_lo",    Lo,          e_lo);
            check("hold_dbz",   div_by_zero, e_dbz);
            check("hold_rdy",   req_ready,   0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("rel_valid", resp_valid, 0);
        check("rel_rdy",   req_ready,  1);
        check("rel_busy",  busy,       0);
        check("rel_hi",    Hi,         last_hi);
        check("rel_lo",    Lo,         last_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        logic [1:0] ro;

        // Reset state
        #1;
        check("rst_req_ready", req_ready,   1);
        check("rst_resp_vld",  resp_valid,  0);
        check("rst_busy",      busy,        0);
        check("rst_dbz",       div_by_zero, 0);
        check("rst_hi",        Hi,          0);
        check("rst_lo",        Lo,          0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // MULT -3 * 7
        issue(2'd0, 32'hFFFF_FFFD, 32'd7, wt); await_resp(); release_resp(0);

        // MULTU max*max, then DIVU held through the backpressured response
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, wt); await_resp();
        op = 2'd3; operandA = 32'd100; operandB = 32'd7; req_valid = 1'b1;
        release_resp(5);
        issue(2'd3, 32'd100, 32'd7, wt);
        check("held_accept_next_edge", wt, 0);
        await_resp(); release_resp(1);

        // Signed divide, including overflow case
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, wt); await_resp(); release_resp(0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, wt); await_resp(); release_resp(0);

        // Divide by zero
        issue(2'd3, 32'h0000_1234, 32'd0, wt); await_resp(); release_resp(2);
        issue(2'd2, 32'hFFFF_FF00, 32'd0, wt); await_resp(); release_resp(0);

        // Zero operands (short path only with the bypass option)
        issue(2'd0, 32'd0, 32'd5, wt); await_resp(); release_resp(0);
        issue(2'd3, 32'd0, 32'd9, wt); await_resp(); release_resp(0);

        // Reset in the middle of a MULT after a nonzero result is held
        issue(2'd1, 32'd3, 32'd5, wt); await_resp(); release_resp(0);
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, wt);
        repeat (9) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check("mid_rst_hi",   Hi,          0);
        check("mid_rst_lo",   Lo,          0);
        check("mid_rst_vld",  resp_valid,  0);
        check("mid_rst_busy", busy,        0);
        check("mid_rst_rdy",  req_ready,   1);
        check("mid_rst_dbz",  div_by_zero, 0);
        last_hi = '0;
        last_lo = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            issue(ro, pick(), pick(), wt);
            await_resp();
            release_resp($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
